cc1200_spi_responder: RTL

- Synthesizable SPI responder (slave) that emulates the CC1200 register interface, acting as the far end of the block-design SPI master lanes (SCLK/MOSI/MISO/CS_n).
- Decodes CC1200 header bytes and handles single and burst register access, extended-address access, command strobes and FIFO access at 0x3F.
- Used as a loopback/bench partner on a spare Pmod lane and in system simulation.
- All SPI inputs are oversampled in the sysclk domain.

---
 rtl/cc1200_spi_responder.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cc1200_spi_responder.sv
// CC1200-style SPI register/FIFO responder; all SPI pins are oversampled on sysclk.
// Optional macro CC1200_SPIR_AUTOINC_WRAP_EN: burst addresses wrap instead of saturating.
`timescale 1ns / 1ps
module cc1200_spi_responder #(
  parameter int unsigned EXT_AW     = 7,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic       sysclk,
  input  logic       rstn,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS_n,
  output logic       MISO,
  input  logic [2:0] chip_state,
  output logic       cmd_strobe,
  output logic [5:0] cmd_addr,
  input  logic [7:0] rxf_wdata,
  input  logic       rxf_wr,
  output logic       rxf_full,
  output logic       rxf_ovf,
  output logic [7:0] txf_data,
  output logic       txf_valid
);
  localparam int unsigned ExtSize  = 2 ** EXT_AW;
  localparam logic [5:0]  NormLast = 6'h2E;
  localparam logic [5:0]  ExtAddr  = 6'h2F;
  localparam logic [5:0]  FifoAddr = 6'h3F;

  typedef enum logic [2:0] {StIdle, StHdr, StExt, StData, StErr} state_e;
  typedef enum logic [1:0] {LdStatus, LdZero, LdRead} load_e;

  state_e           r_state, w_state_nxt;
  load_e            w_load_sel;
  logic [2:0]       r_sclk_s, r_csn_s;
  logic [1:0]       r_mosi_s;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_rx, r_shift, w_rx_byte, w_status, w_rd_val;
  logic             r_rw, r_burst, r_ext, r_live, r_sat, r_strb_md;
  logic             w_rw_nxt, w_burst_nxt, w_ext_nxt, w_live_nxt, w_sat_nxt, w_strb_md_nxt;
  logic [5:0]       r_addr, w_addr_nxt;
  logic [7:0]       r_eaddr, w_eaddr_nxt;
  logic [7:0]       r_norm [0:46];
  logic [7:0]       r_xmem [0:ExtSize-1];
  logic [7:0]       r_fifo [0:FIFO_DEPTH-1];
  logic [FIFO_AW:0] r_wptr, r_rptr;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_byte_done;
  logic w_load, w_strobe, w_wr_en, w_wr_norm, w_wr_ext, w_wr_fifo;
  logic w_cur_ok, w_cur_last, w_fifo_empty, w_pop, w_push;

  // Index [1] is the synchronized level, [2] the previous sample for edge detection.
  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      r_sclk_s <= '0;
      r_csn_s  <= '1;
      r_mosi_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], SCLK};
      r_csn_s  <= {r_csn_s[1:0], CS_n};
      r_mosi_s <= {r_mosi_s[0], MOSI};
    end
  end

  assign w_sclk_rise  = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_sclk_fall  = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_cs_rise    = r_csn_s[1] & ~r_csn_s[2];
  assign w_cs_fall    = ~r_csn_s[1] & r_csn_s[2];
  assign w_rx_byte    = {r_rx[6:0], r_mosi_s[1]};
  assign w_byte_done  = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_status     = {1'b0, chip_state, 4'b0000};
  assign w_fifo_empty = (r_wptr == r_rptr);
  assign rxf_full     = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                        (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_cur_ok     = r_ext ? (32'(r_eaddr) < ExtSize) : (r_addr <= NormLast);
  assign w_cur_last   = r_ext ? (32'(r_eaddr) == ExtSize - 1) : (r_addr == NormLast);

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_load_sel    = LdStatus;
    w_strobe      = 1'b0;
    w_wr_en       = 1'b0;
    w_rw_nxt      = r_rw;
    w_burst_nxt   = r_burst;
    w_ext_nxt     = r_ext;
    w_live_nxt    = r_live;
    w_sat_nxt     = r_sat;
    w_strb_md_nxt = r_strb_md;
    w_addr_nxt    = r_addr;
    w_eaddr_nxt   = r_eaddr;
    if (w_cs_rise) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_cs_fall) begin
            if (r_sclk_s[1]) begin
              w_state_nxt = StErr;
            end else begin
              w_state_nxt = StHdr;
              w_load      = 1'b1;
            end
          end
        end
        StHdr: begin
          if (w_byte_done) begin
            w_load        = 1'b1;
            w_rw_nxt      = w_rx_byte[7];
            w_burst_nxt   = w_rx_byte[6];
            w_addr_nxt    = w_rx_byte[5:0];
            w_ext_nxt     = (w_rx_byte[5:0] == ExtAddr);
            w_live_nxt    = 1'b1;
            w_sat_nxt     = 1'b0;
            w_strb_md_nxt = (w_rx_byte[5:0] >= 6'h30) && (w_rx_byte[5:0] <= 6'h3D);
            if (w_ext_nxt) begin
              w_state_nxt = StExt;
              w_load_sel  = LdZero;
            end else begin
              w_state_nxt = StData;
              w_strobe    = w_strb_md_nxt;
              if (w_rx_byte[7] && !w_strb_md_nxt) w_load_sel = LdRead;
            end
          end
        end
        StExt: begin
          if (w_byte_done) begin
            w_load      = 1'b1;
            w_state_nxt = StData;
            w_eaddr_nxt = w_rx_byte;
            if (r_rw) w_load_sel = LdRead;
          end
        end
        StData: begin
          if (w_byte_done) begin
            w_load = 1'b1;
            if (!r_strb_md) begin
              w_wr_en = !r_rw && r_live;
              // FIFO and out-of-range addresses fail w_cur_ok and therefore never advance.
              if (!r_burst) begin
                w_live_nxt = 1'b0;
              end else if (r_live && w_cur_ok) begin
                if (w_cur_last) begin
`ifdef CC1200_SPIR_AUTOINC_WRAP_EN
                  w_addr_nxt  = r_ext ? r_addr : 6'd0;
                  w_eaddr_nxt = r_ext ? 8'd0 : r_eaddr;
`else
                  w_live_nxt  = 1'b0;
                  w_sat_nxt   = 1'b1;
`endif
                end else if (r_ext) begin
                  w_eaddr_nxt = r_eaddr + 8'd1;
                end else begin
                  w_addr_nxt = r_addr + 6'd1;
                end
              end
              if (r_rw) w_load_sel = w_live_nxt ? LdRead : (w_sat_nxt ? LdZero : LdStatus);
            end
          end
        end
        StErr: ;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    w_rd_val = 8'h00;
    if (w_ext_nxt) begin
      if (32'(w_eaddr_nxt) < ExtSize) w_rd_val = r_xmem[w_eaddr_nxt[EXT_AW-1:0]];
    end else if (w_addr_nxt == FifoAddr) begin
      if (!w_fifo_empty) w_rd_val = r_fifo[r_rptr[FIFO_AW-1:0]];
    end else if (w_addr_nxt <= NormLast) begin
      w_rd_val = r_norm[w_addr_nxt];
    end
  end

  assign w_pop     = w_load && (w_load_sel == LdRead) && !w_ext_nxt &&
                     (w_addr_nxt == FifoAddr) && !w_fifo_empty;
  assign w_push    = rxf_wr && (!rxf_full || w_pop);
  assign w_wr_norm = w_wr_en && !r_ext && (r_addr <= NormLast);
  assign w_wr_ext  = w_wr_en && r_ext && (32'(r_eaddr) < ExtSize);
  assign w_wr_fifo = w_wr_en && !r_ext && (r_addr == FifoAddr);
  assign MISO      = r_shift[7];

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_rw      <= 1'b0;
      r_burst   <= 1'b0;
      r_ext     <= 1'b0;
      r_live    <= 1'b0;
      r_sat     <= 1'b0;
      r_strb_md <= 1'b0;
      r_addr    <= '0;
      r_eaddr   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rw      <= w_rw_nxt;
      r_burst   <= w_burst_nxt;
      r_ext     <= w_ext_nxt;
      r_live    <= w_live_nxt;
      r_sat     <= w_sat_nxt;
      r_strb_md <= w_strb_md_nxt;
      r_addr    <= w_addr_nxt;
      r_eaddr   <= w_eaddr_nxt;
    end
  end

  // No shift on the falling edge that follows a byte-completing rise: the preloaded MSB holds.
  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_rx      <= '0;
    end else if (w_state_nxt == StIdle || w_state_nxt == StErr) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_load) begin
        case (w_load_sel)
          LdRead:  r_shift <= w_rd_val;
          LdZero:  r_shift <= 8'h00;
          default: r_shift <= w_status;
        endcase
      end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
      if (w_sclk_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_rx_byte;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      for (int i = 0; i < 47; i++) r_norm[i] <= '0;
      for (int i = 0; i < int'(ExtSize); i++) r_xmem[i] <= '0;
    end else begin
      if (w_wr_norm) r_norm[r_addr] <= w_rx_byte;
      if (w_wr_ext) r_xmem[r_eaddr[EXT_AW-1:0]] <= w_rx_byte;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr[FIFO_AW-1:0]] <= rxf_wdata;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      cmd_strobe <= 1'b0;
      cmd_addr   <= '0;
      txf_valid  <= 1'b0;
      txf_data   <= '0;
      rxf_ovf    <= 1'b0;
    end else begin
      cmd_strobe <= w_strobe;
      if (w_strobe) cmd_addr <= w_addr_nxt;
      txf_valid <= w_wr_fifo;
      if (w_wr_fifo) txf_data <= w_rx_byte;
      rxf_ovf <= rxf_ovf | (rxf_wr & ~w_push);
    end
  end
endmodule
